// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_is_div;
  logic                 r_qsign;
  logic                 r_rsign;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_a_raw;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_dz_out;

  logic                 w_start;
  logic                 w_wb;
  logic                 w_signed;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_hi_res;
  logic [WIDTH-1:0]     w_lo_res;

  assign w_start  = (r_state == S_IDLE) && start && !cancel;
  assign w_wb     = (r_state == S_FIX) && !cancel;
  assign w_signed = !op[0];
  assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_m : '0)};
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient}; one extra bit on the shifted remainder
  // so the trial subtraction borrow is visible.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_qbit     = !w_diff[WIDTH];
  assign w_div_step = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_qbit};

  assign w_prod = r_qsign ? -r_acc : r_acc;
  assign w_quot = r_qsign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_rsign ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi_res = w_prod[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_hi_res = r_a_raw;
        w_lo_res = '1;
      end else begin
        w_hi_res = w_rem;
        w_lo_res = w_quot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && !cancel) w_next = S_RUN;
      S_RUN: begin
        if (cancel) begin
          w_next = S_IDLE;
        end else if (r_cnt == c_LAST) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_dz     <= 1'b0;
      r_m      <= '0;
      r_a_raw  <= '0;
      r_acc    <= '0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_is_div <= op[1];
      r_qsign  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_rsign  <= w_signed && a[WIDTH-1];
      r_dz     <= op[1] && (b == '0);
      r_m      <= w_abs_b;
      r_a_raw  <= a;
      r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
    end else if ((r_state == S_RUN) && !cancel) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= r_is_div ? w_div_step : w_mul_step;
    end
  end

  // Write-back takes priority over MTHI/MTLO landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
    end else begin
      r_done   <= w_wb;
      r_dz_out <= w_wb && r_is_div && r_dz;
      if (w_wb) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end else begin
        if (hi_we) r_hi <= hi_wdata;
        if (lo_we) r_lo <= lo_wdata;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign dz   = r_dz_out;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire
